// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with credit-limited prefetch queue
module fetch_unit #(
  parameter int                 WIDTH    = 32,
  parameter int                 DEPTH    = 4,
  parameter logic [WIDTH-1:0]   RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             mem_req_valid,
  input  logic             mem_req_ready,
  output logic [WIDTH-1:0] mem_req_addr,
  input  logic             mem_resp_valid,
  input  logic [WIDTH-1:0] mem_resp_data,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [WIDTH-1:0] instr,
  output logic [WIDTH-1:0] instr_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0]   LP_DEPTH_W = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] LP_FULL    = CW'(DEPTH);
  localparam logic [WIDTH-1:0] LP_STEP = WIDTH'(4);

  logic [WIDTH-1:0] r_q_instr [DEPTH];
  logic [WIDTH-1:0] r_q_pc    [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  // total requests accepted by memory and not yet answered, stale ones included
  logic [CW-1:0]    r_outstanding;
  // how many of the oldest outstanding responses belong to a flushed stream
  logic [CW-1:0]    r_discard;
  logic [WIDTH-1:0] r_fetch_pc;
  logic [WIDTH-1:0] r_resp_pc;

  logic [CW:0] w_used;
  logic        w_req_valid;
  logic        w_req_fire;
  logic        w_drop;
  logic        w_push;
  logic        w_pop;
  logic        w_instr_valid;

  // queued plus in-flight words may never exceed the queue size, so every response has a slot;
  // gated with rst so nothing is requested while reset is held
  assign w_used        = {1'b0, r_count} + {1'b0, r_outstanding};
  assign w_req_valid   = rst && !redirect && (w_used < LP_DEPTH_W);
  assign w_req_fire    = w_req_valid && mem_req_ready;
  assign w_drop        = (r_discard != '0);
  assign w_push        = mem_resp_valid && !redirect && !w_drop;
  assign w_instr_valid = (r_count != '0);
  assign w_pop         = w_instr_valid && instr_ready && !redirect;

  assign mem_req_valid = w_req_valid;
  assign mem_req_addr  = r_fetch_pc;
  assign instr_valid   = w_instr_valid;
  assign instr         = w_instr_valid ? r_q_instr[r_rd_ptr] : '0;
  assign instr_pc      = w_instr_valid ? r_q_pc[r_rd_ptr]    : '0;

  // control state: PCs, queue pointers and the in-flight / discard bookkeeping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_outstanding <= '0;
      r_discard     <= '0;
    end else if (redirect) begin
      // everything still in flight after this cycle is stale, including what was already marked
      r_fetch_pc    <= redirect_pc;
      r_resp_pc     <= redirect_pc;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_outstanding <= r_outstanding - CW'(mem_resp_valid);
      r_discard     <= r_outstanding - CW'(mem_resp_valid);
    end else begin
      if (w_req_fire) begin
        r_fetch_pc <= r_fetch_pc + LP_STEP;
      end
      r_outstanding <= r_outstanding + CW'(w_req_fire) - CW'(mem_resp_valid);
      if (mem_resp_valid && w_drop) begin
        r_discard <= r_discard - CW'(1);
      end
      if (w_push) begin
        r_wr_ptr  <= r_wr_ptr + AW'(1);
        r_resp_pc <= r_resp_pc + LP_STEP;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // queue storage; contents are only visible while the entry is counted as valid
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_instr[r_wr_ptr] <= mem_resp_data;
      r_q_pc[r_wr_ptr]    <= r_resp_pc;
    end
  end

  // a response must match an accepted request, and the credit rule keeps the queue from overflowing
  a_resp_has_req: assert property (@(posedge clk) disable iff (!rst)
    !(mem_resp_valid && (r_outstanding == '0)));
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(w_push && (r_count == LP_FULL)));

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_data = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  always #5 clk = ~clk;

  fetch_unit #(.WIDTH(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc)
  );

  int n_vec = 0;
  int n_err = 0;

  // reference model and memory state
  logic [31:0] m_fetch = '0;
  int          m_cnt = 0;
  int          m_disc = 0;
  logic [31:0] exp_q[$];
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  int          cyc = 0;
  int          last_due = -1;

  int          g_lat_min = 1, g_lat_max = 1, g_rr = 100, g_ir = 100;
  bit          g_redir = 1'b0;
  logic [31:0] g_rpc = '0;

  typedef struct {
    bit          do_rst;
    bit          ir;
    bit          exp_rv;
    logic [31:0] exp_ra;
    bit          exp_iv;
    logic [31:0] exp_ipc;
  } vec_t;
  vec_t vt[17];

  function automatic logic [31:0] memw(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    pend_addr.delete();
    pend_due.delete();
    m_fetch  = 32'h0;
    m_cnt    = 0;
    m_disc   = 0;
    last_due = -1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    redirect = 1'b0;
    g_redir = 1'b0;
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0;
    instr_ready = 1'b0;
    clear_model();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // one clock: drive inputs at negedge, check outputs against the model, advance the model
  task automatic cycle();
    bit fire, resp, pop, exp_rv;
    int lat;
    @(negedge clk);
    redirect      = g_redir;
    redirect_pc   = g_rpc;
    mem_req_ready = (int'($urandom_range(0, 99)) < g_rr);
    instr_ready   = (int'($urandom_range(0, 99)) < g_ir);
    resp = (pend_addr.size() != 0) && (pend_due[0] <= cyc);
    mem_resp_valid = resp;
    mem_resp_data  = resp ? memw(pend_addr[0]) : 32'hDEAD_BEEF;
    #1;
    exp_rv = !g_redir && (m_cnt + pend_addr.size() < 4);
    chk("req_valid", 32'(mem_req_valid), 32'(exp_rv));
    if (exp_rv && mem_req_valid) chk("req_addr", mem_req_addr, m_fetch);
    chk("instr_valid", 32'(instr_valid), 32'(m_cnt != 0));
    if (instr_valid && m_cnt != 0) begin
      chk("instr_pc", instr_pc, exp_q[0]);
      chk("instr", instr, memw(exp_q[0]));
    end
    fire = exp_rv && mem_req_ready;
    pop  = (m_cnt != 0) && instr_ready && !g_redir;
    if (resp) begin
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end
    if (g_redir) begin
      exp_q.delete();
      m_cnt   = 0;
      m_disc  = pend_addr.size();
      m_fetch = g_rpc;
    end else begin
      if (pop) begin
        void'(exp_q.pop_front());
        m_cnt--;
      end
      if (resp) begin
        if (m_disc > 0) m_disc--;
        else m_cnt++;
      end
      if (fire) begin
        exp_q.push_back(m_fetch);
        lat = int'($urandom_range(g_lat_min, g_lat_max));
        last_due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
        pend_addr.push_back(m_fetch);
        pend_due.push_back(last_due);
        m_fetch += 32'd4;
      end
    end
    cyc++;
  endtask

  task automatic wait_first(input string name, input logic [31:0] pc);
    bit found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      cycle();
      if (instr_valid) begin
        chk({name, "_pc"}, instr_pc, pc);
        chk({name, "_data"}, instr, memw(pc));
        found = 1'b1;
      end
    end
    if (!found) chk({name, "_timeout"}, 32'h0, 32'h1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // streaming 1-cycle memory, then backpressure filling the queue and draining it
    vt[0]  = '{1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
    vt[1]  = '{1'b0, 1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
    vt[2]  = '{1'b0, 1'b1, 1'b1, 32'h08, 1'b1, 32'h00};
    vt[3]  = '{1'b0, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h04};
    vt[4]  = '{1'b0, 1'b1, 1'b1, 32'h10, 1'b1, 32'h08};
    vt[5]  = '{1'b0, 1'b1, 1'b1, 32'h14, 1'b1, 32'h0C};
    vt[6]  = '{1'b1, 1'b0, 1'b1, 32'h00, 1'b0, 32'h00};
    vt[7]  = '{1'b0, 1'b0, 1'b1, 32'h04, 1'b0, 32'h00};
    vt[8]  = '{1'b0, 1'b0, 1'b1, 32'h08, 1'b1, 32'h00};
    vt[9]  = '{1'b0, 1'b0, 1'b1, 32'h0C, 1'b1, 32'h00};
    vt[10] = '{1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 32'h00};
    vt[11] = '{1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 32'h00};
    vt[12] = '{1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 32'h00};
    vt[13] = '{1'b0, 1'b1, 1'b1, 32'h10, 1'b1, 32'h04};
    vt[14] = '{1'b0, 1'b1, 1'b1, 32'h14, 1'b1, 32'h08};
    vt[15] = '{1'b0, 1'b1, 1'b1, 32'h18, 1'b1, 32'h0C};
    vt[16] = '{1'b0, 1'b1, 1'b1, 32'h1C, 1'b1, 32'h10};

    #1;
    chk("rst_req_valid", 32'(mem_req_valid), 32'h0);
    chk("rst_instr_valid", 32'(instr_valid), 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);

    g_lat_min = 1; g_lat_max = 1; g_rr = 100;
    foreach (vt[i]) begin
      if (vt[i].do_rst) do_reset();
      g_ir = vt[i].ir ? 100 : 0;
      cycle();
      chk("tbl_req_valid", 32'(mem_req_valid), 32'(vt[i].exp_rv));
      if (vt[i].exp_rv) chk("tbl_req_addr", mem_req_addr, vt[i].exp_ra);
      chk("tbl_instr_valid", 32'(instr_valid), 32'(vt[i].exp_iv));
      if (vt[i].exp_iv) chk("tbl_instr_pc", instr_pc, vt[i].exp_ipc);
    end

    // latency 3, two requests in flight when redirecting
    do_reset();
    g_lat_min = 3; g_lat_max = 3; g_rr = 100; g_ir = 100;
    cycle();
    cycle();
    g_redir = 1'b1; g_rpc = 32'h100;
    cycle();
    chk("redir_no_req", 32'(mem_req_valid), 32'h0);
    g_redir = 1'b0;
    cycle();
    chk("redir_next_addr", mem_req_addr, 32'h100);
    wait_first("redir_first", 32'h100);

    // redirect coinciding with a response and a pop
    do_reset();
    g_lat_min = 2; g_lat_max = 2;
    repeat (6) cycle();
    g_redir = 1'b1; g_rpc = 32'h200;
    cycle();
    chk("same_cyc_ivalid", 32'(instr_valid), 32'h1);
    chk("same_cyc_resp", 32'(mem_resp_valid), 32'h1);
    g_redir = 1'b0;
    cycle();
    chk("post_redir_ivalid", 32'(instr_valid), 32'h0);
    chk("post_redir_addr", mem_req_addr, 32'h200);
    wait_first("post_redir_first", 32'h200);
    repeat (10) cycle();

    // address wrap at the top of the space
    g_lat_min = 1; g_lat_max = 3;
    g_redir = 1'b1; g_rpc = 32'hFFFF_FFF8;
    cycle();
    g_redir = 1'b0;
    wait_first("wrap_first", 32'hFFFF_FFF8);
    repeat (20) cycle();

    // random handshakes, latencies and redirects
    g_lat_min = 1; g_lat_max = 5; g_rr = 50; g_ir = 50;
    for (int i = 0; i < 2000; i++) begin
      g_redir = (int'($urandom_range(0, 99)) < 3);
      g_rpc   = 32'($urandom_range(0, 16383)) << 2;
      cycle();
    end
    g_redir = 1'b0;

    // asynchronous reset in the middle of a burst
    g_lat_min = 2; g_lat_max = 2; g_rr = 100; g_ir = 0;
    repeat (4) cycle();
    #2;
    rst = 1'b0;
    #1;
    chk("async_req_valid", 32'(mem_req_valid), 32'h0);
    chk("async_instr_valid", 32'(instr_valid), 32'h0);
    chk("async_instr", instr, 32'h0);
    chk("async_instr_pc", instr_pc, 32'h0);
    clear_model();
    mem_resp_valid = 1'b0;
    mem_req_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    g_ir = 100;
    cycle();
    chk("after_rst_valid", 32'(mem_req_valid), 32'h1);
    chk("after_rst_addr", mem_req_addr, 32'h0);
    wait_first("after_rst_first", 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
